// File: rtl/sparc_exu_thr_regctl_if.sv
// Bus between the EXU pipeline / aux writer and sparc_exu_thr_regctl.
// aux_req is a level request held until aux_ack; aux_ack pulses on the cycle the aux write sits at W.
// A request still high on the aux_ack cycle is the old one and is ignored; high on the next cycle it is new.
interface sparc_exu_thr_regctl_if #(
   parameter int SIZE = 3
);
   logic [3:0]      thr_rdy;
   logic            stall;
   logic            wen_e;
   logic            kill_e;
   logic            kill_m;
   logic [SIZE-1:0] data_m;
   logic            aux_req;
   logic [1:0]      aux_thr;
   logic [SIZE-1:0] aux_data;
   logic [3:0]      thr_out;
   logic [3:0]      thr_w;
   logic            wen_w;
   logic [SIZE-1:0] data_in_w;
   logic            aux_ack;
   logic            issue_blk;

   modport master (
      output thr_rdy, stall, wen_e, kill_e, kill_m, data_m, aux_req, aux_thr, aux_data,
      input  thr_out, thr_w, wen_w, data_in_w, aux_ack, issue_blk
   );

   modport slave (
      input  thr_rdy, stall, wen_e, kill_e, kill_m, data_m, aux_req, aux_thr, aux_data,
      output thr_out, thr_w, wen_w, data_in_w, aux_ack, issue_blk
   );
endinterface

// File: rtl/sparc_exu_thr_regctl.sv
// Round-robin thread picker with E/M/W write tracking for the EXU per-thread register bank.
// Aux write merge and starvation throttle are built only when EXU_REGCTL_AUX_EN is defined.
module sparc_exu_thr_regctl #(
   parameter int SIZE     = 3,
   parameter int AUX_WAIT = 4
) (
   input logic                   clk,
   input logic                   reset,
   input logic                   se,
   sparc_exu_thr_regctl_if.slave bus
);

   logic [1:0]      last;
   logic [1:0]      idx;
   logic [1:0]      pick;
   logic            any_rdy;
   logic [3:0]      thr_s;
   logic            vld_s;
   logic [3:0]      thr_e;
   logic            vld_e;
   logic [3:0]      thr_m;
   logic            wr_m;
   logic            m_wr_ok;
   logic            aux_go;
   logic [3:0]      aux_dec;
   logic [SIZE-1:0] aux_wdata;
   logic            blk;
   logic [3:0]      thr_w_q;
   logic            wen_w_q;
   logic [SIZE-1:0] data_w_q;
   logic            ack_q;
   logic            unused_ok;

   // Scan from the lowest-priority slot (last itself) down to last+1, so last+1 wins.
   always_comb begin
      idx     = '0;
      pick    = last;
      any_rdy = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (bus.thr_rdy[idx]) begin
            pick    = idx;
            any_rdy = 1'b1;
         end
      end
   end

   assign thr_s = any_rdy ? (4'b0001 << pick) : 4'b0000;
   assign vld_s = any_rdy & ~blk;

   always_ff @(posedge clk) begin
      if (reset) begin
         last  <= 2'd3;
         thr_e <= '0;
         vld_e <= 1'b0;
         thr_m <= '0;
         wr_m  <= 1'b0;
      end else begin
         if (!bus.stall) begin
            thr_e <= thr_s;
            vld_e <= vld_s;
            if (vld_s) last <= pick;
         end
         thr_m <= thr_e;
         wr_m  <= vld_e & bus.wen_e & ~bus.kill_e & ~bus.stall;
      end
   end

   assign m_wr_ok = wr_m & ~bus.kill_m;

`ifdef EXU_REGCTL_AUX_EN
   localparam int            CW      = $clog2(AUX_WAIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(AUX_WAIT);

   logic [CW-1:0] aux_cnt;

   // The request seen on the ack cycle is the one just served, so it cannot win the slot again.
   assign aux_go    = bus.aux_req & ~ack_q & ~m_wr_ok;
   assign aux_dec   = 4'b0001 << bus.aux_thr;
   assign aux_wdata = bus.aux_data;
   assign blk       = (aux_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset || !bus.aux_req || ack_q)
         aux_cnt <= '0;
      else if (!aux_go && aux_cnt != CNT_MAX)
         aux_cnt <= aux_cnt + 1'b1;
   end

   assign bus.aux_ack   = ack_q;
   assign bus.issue_blk = blk;
   assign unused_ok     = se;
`else
   assign aux_go        = 1'b0;
   assign aux_dec       = 4'b0000;
   assign aux_wdata     = '0;
   assign blk           = 1'b0;
   assign bus.aux_ack   = 1'b0;
   assign bus.issue_blk = 1'b0;
   assign unused_ok     = ^{se, ack_q, bus.aux_req, bus.aux_thr, bus.aux_data};
`endif

   // Instruction writes always own the W slot; aux only fills slots the pipe leaves empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         thr_w_q  <= '0;
         wen_w_q  <= 1'b0;
         data_w_q <= '0;
         ack_q    <= 1'b0;
      end else if (m_wr_ok) begin
         thr_w_q  <= thr_m;
         wen_w_q  <= 1'b1;
         data_w_q <= bus.data_m;
         ack_q    <= 1'b0;
      end else if (aux_go) begin
         thr_w_q  <= aux_dec;
         wen_w_q  <= 1'b1;
         data_w_q <= aux_wdata;
         ack_q    <= 1'b1;
      end else begin
         thr_w_q  <= '0;
         wen_w_q  <= 1'b0;
         ack_q    <= 1'b0;
      end
   end

   assign bus.thr_out   = vld_e ? thr_e : 4'b0000;
   assign bus.thr_w     = thr_w_q;
   assign bus.wen_w     = wen_w_q;
   assign bus.data_in_w = data_w_q;

endmodule

// File: tb/tb_sparc_exu_thr_regctl.sv
// Bench for sparc_exu_thr_regctl: directed pipeline scenarios plus random traffic against a cycle model.
// Follows the EXU_REGCTL_AUX_EN build of the design for aux expectations.
module tb_sparc_exu_thr_regctl;

   localparam int SIZE     = 3;
   localparam int AUX_WAIT = 4;
   localparam int EW       = SIZE + 11;
`ifdef EXU_REGCTL_AUX_EN
   localparam bit AUX_EN = 1'b1;
`else
   localparam bit AUX_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic se;

   always #5 clk = ~clk;

   sparc_exu_thr_regctl_if #(.SIZE(SIZE)) bus ();

   sparc_exu_thr_regctl #(.SIZE(SIZE), .AUX_WAIT(AUX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .se    (se),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   // reference model: thread numbers as ints, one-hot produced only at the outputs
   int m_last, m_e_thr, m_m_thr, m_thr_w, m_data, m_cnt;
   bit m_e_vld, m_m_wr, m_wen, m_ack;
   bit drop_next;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last  = 3;
      m_e_vld = 0;
      m_e_thr = 0;
      m_m_wr  = 0;
      m_m_thr = 0;
      m_thr_w = 0;
      m_wen   = 0;
      m_data  = 0;
      m_ack   = 0;
      m_cnt   = 0;
   endtask

   // One clock edge of the reference behaviour, from current model state and current inputs.
   task automatic model_edge();
      int pick;
      bit blocked_pick, m_ok, pend;
      if (reset) begin
         model_reset();
         return;
      end
      blocked_pick = AUX_EN && (m_cnt == AUX_WAIT);
      pick = -1;
      if (!blocked_pick)
         for (int k = 1; k <= 4; k++)
            if (pick < 0 && bus.thr_rdy[(m_last + k) % 4]) pick = (m_last + k) % 4;
      m_ok = m_m_wr && !bus.kill_m;
      pend = AUX_EN && bus.aux_req && !m_ack;
      if (!AUX_EN || !bus.aux_req || m_ack) m_cnt = 0;
      else if (m_ok && m_cnt < AUX_WAIT) m_cnt = m_cnt + 1;
      if (m_ok) begin
         m_thr_w = 1 << m_m_thr;
         m_wen   = 1;
         m_data  = int'(bus.data_m);
         m_ack   = 0;
      end else if (pend) begin
         m_thr_w = 1 << bus.aux_thr;
         m_wen   = 1;
         m_data  = int'(bus.aux_data);
         m_ack   = 1;
      end else begin
         m_thr_w = 0;
         m_wen   = 0;
         m_ack   = 0;
      end
      m_m_wr  = m_e_vld && bus.wen_e && !bus.kill_e && !bus.stall;
      m_m_thr = m_e_thr;
      if (!bus.stall) begin
         m_e_vld = (pick >= 0);
         if (pick >= 0) begin
            m_e_thr = pick;
            m_last  = pick;
         end
      end
   endtask

   function automatic logic [EW-1:0] model_out();
      logic [3:0] t_out;
      t_out = m_e_vld ? 4'(1 << m_e_thr) : 4'b0000;
      return {t_out, 4'(m_thr_w), m_wen, SIZE'(m_data), m_ack, (AUX_EN && m_cnt == AUX_WAIT)};
   endfunction

   task automatic scoreboard();
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("thr_out",   32'(bus.thr_out),   32'(e[SIZE+10:SIZE+7]));
      check("thr_w",     32'(bus.thr_w),     32'(e[SIZE+6:SIZE+3]));
      check("wen_w",     32'(bus.wen_w),     32'(e[SIZE+2]));
      check("data_in_w", 32'(bus.data_in_w), 32'(e[SIZE+1:2]));
      check("aux_ack",   32'(bus.aux_ack),   32'(e[1]));
      check("issue_blk", 32'(bus.issue_blk), 32'(e[0]));
      check("w_onehot",  32'($onehot0(bus.thr_w) && (!bus.wen_w || bus.thr_w != 4'b0000)), 32'(1));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_edge();
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      scoreboard();
   endtask

   task automatic drive_idle();
      bus.thr_rdy  = 4'b0000;
      bus.stall    = 1'b0;
      bus.wen_e    = 1'b0;
      bus.kill_e   = 1'b0;
      bus.kill_m   = 1'b0;
      bus.data_m   = '0;
      bus.aux_req  = 1'b0;
      bus.aux_thr  = 2'd0;
      bus.aux_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // ---------------- directed tables (index = cycle after reset) ----------------
   logic [3:0] rr_out [1:6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
   logic [3:0] rr_w   [1:6] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
   logic [3:0] st_out [1:9] = '{4'h1, 4'h4, 4'h1, 4'h4, 4'h4, 4'h4, 4'h1, 4'h4, 4'h1};
   logic [3:0] st_w   [1:9] = '{4'h0, 4'h0, 4'h1, 4'h4, 4'h1, 4'h0, 4'h0, 4'h4, 4'h1};
   logic [3:0] kl_w   [1:7] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h8, 4'h1};

   initial begin
      int blk_step, ack_step;
      bit blk_hist [1:12];
      se    = 1'b0;
      reset = 1'b1;
      drive_idle();
      model_reset();

      // reset state
      do_reset();
      check("rst_thr_out", 32'(bus.thr_out), 32'(0));
      check("rst_wen_w",   32'(bus.wen_w),   32'(0));

      // round robin, all threads ready
      do_reset();
      bus.thr_rdy = 4'b1111;
      bus.wen_e   = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         bus.data_m = SIZE'($urandom_range((1 << SIZE) - 1));
         step();
         check("rr_thr_out", 32'(bus.thr_out), 32'(rr_out[c]));
         check("rr_thr_w",   32'(bus.thr_w),   32'(rr_w[c]));
         check("rr_wen_w",   32'(bus.wen_w),   32'(rr_w[c] != 4'h0));
      end

      // stall for two cycles with threads 0 and 2 ready
      do_reset();
      bus.thr_rdy = 4'b0101;
      bus.wen_e   = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         bus.stall = (c == 5 || c == 6);
         step();
         check("st_thr_out", 32'(bus.thr_out), 32'(st_out[c]));
         check("st_thr_w",   32'(bus.thr_w),   32'(st_w[c]));
         check("st_wen_w",   32'(bus.wen_w),   32'(st_w[c] != 4'h0));
      end
      bus.stall = 1'b0;

      // kill_e on thread 1, kill_m on thread 2
      do_reset();
      bus.thr_rdy = 4'b1111;
      bus.wen_e   = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         bus.kill_e = (c == 3);
         bus.kill_m = (c == 5);
         step();
         check("kl_thr_w", 32'(bus.thr_w), 32'(kl_w[c]));
         check("kl_wen_w", 32'(bus.wen_w), 32'(kl_w[c] != 4'h0));
      end
      bus.kill_e = 1'b0;
      bus.kill_m = 1'b0;

      // aux write into an idle pipe
      do_reset();
      drive_idle();
      step();
      bus.aux_req  = 1'b1;
      bus.aux_thr  = 2'd2;
      bus.aux_data = 3'b101;
      step();
      check("aux_ack",    32'(bus.aux_ack),   32'(AUX_EN));
      check("aux_wen_w",  32'(bus.wen_w),     32'(AUX_EN));
      check("aux_thr_w",  32'(bus.thr_w),     AUX_EN ? 32'(4) : 32'(0));
      check("aux_data_w", 32'(bus.data_in_w), AUX_EN ? 32'(5) : 32'(0));
      step();
      check("aux_ack_once", 32'(bus.aux_ack), 32'(0));
      check("aux_wen_once", 32'(bus.wen_w),   32'(0));
      bus.aux_req = 1'b0;
      step();
      check("aux_ack_idle", 32'(bus.aux_ack), 32'(0));

      // starvation guard with a pipe that writes every cycle
      do_reset();
      bus.thr_rdy = 4'b1111;
      bus.wen_e   = 1'b1;
      repeat (4) step();
      bus.aux_req  = 1'b1;
      bus.aux_thr  = 2'd1;
      bus.aux_data = 3'b110;
      blk_step = 0;
      ack_step = 0;
      for (int n = 1; n <= 12; n++) begin
         step();
         blk_hist[n] = bus.issue_blk;
         if (bus.issue_blk && blk_step == 0) blk_step = n;
         if (bus.aux_ack && ack_step == 0) ack_step = n;
         if (m_ack) bus.aux_req = 1'b0;
      end
      bus.aux_req = 1'b0;
      check("stv_blk_step", 32'(blk_step),    AUX_EN ? 32'(4) : 32'(0));
      check("stv_ack_step", 32'(ack_step),    AUX_EN ? 32'(7) : 32'(0));
      check("stv_blk_ack",  32'(blk_hist[7]), 32'(AUX_EN));
      check("stv_blk_drop", 32'(blk_hist[8]), 32'(0));

      // reset while aux pending and the pipe is full
      bus.aux_req = 1'b1;
      repeat (3) step();
      do_reset();
      check("rf_thr_out",   32'(bus.thr_out),   32'(0));
      check("rf_thr_w",     32'(bus.thr_w),     32'(0));
      check("rf_wen_w",     32'(bus.wen_w),     32'(0));
      check("rf_data_in_w", 32'(bus.data_in_w), 32'(0));
      check("rf_aux_ack",   32'(bus.aux_ack),   32'(0));
      check("rf_issue_blk", 32'(bus.issue_blk), 32'(0));
      bus.aux_req = 1'b0;
      step();
      check("rf_no_ack", 32'(bus.aux_ack), 32'(0));

      // random traffic
      drive_idle();
      drop_next = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         bus.thr_rdy = 4'($urandom_range(15));
         bus.stall   = ($urandom_range(4) == 0);
         bus.wen_e   = ($urandom_range(3) != 0);
         bus.kill_e  = ($urandom_range(5) == 0);
         bus.kill_m  = ($urandom_range(5) == 0);
         bus.data_m  = SIZE'($urandom_range((1 << SIZE) - 1));
         if (bus.aux_req) begin
            if (drop_next) begin
               bus.aux_req = 1'b0;
               drop_next   = 1'b0;
            end else if (m_ack) begin
               if ($urandom_range(1) == 0) bus.aux_req = 1'b0;
               else drop_next = 1'b1;
            end
         end else if ($urandom_range(5) == 0) begin
            bus.aux_req  = 1'b1;
            bus.aux_thr  = 2'($urandom_range(3));
            bus.aux_data = SIZE'($urandom_range((1 << SIZE) - 1));
         end
         if ($urandom_range(249) == 0) begin
            do_reset();
            bus.aux_req = 1'b0;
            drop_next   = 1'b0;
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
